// File: rtl/smpl_hit_chk.sv
// smpl_hit_chk: per-lane triangle hit predictor with an in-order expect FIFO.
// Compares queued masks against DUT result strobes; keeps counters, flags, halt.
module smpl_hit_chk #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int MULTI_SAMP = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LAT    = 32,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  input  logic [MULTI_SAMP-1:0][1:0][SIGFIG-1:0] sample_R16S,
  input  logic                    validSamp_R16H,
  input  logic                    result_valid_R18H,
  input  logic [MULTI_SAMP-1:0]   hit_valid_R18H,
  input  logic                    flush,
  output logic [CNT_W-1:0]        check_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [MULTI_SAMP-1:0]   err_lane_mask,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    timeout,
  output logic                    halted,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int DW = SIGFIG + 1;
  localparam int PW = 2 * SIGFIG + 2;
  localparam int EW = 2 * SIGFIG + 3;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  function automatic logic signed [EW-1:0] edge_f(
    input logic [SIGFIG-1:0] ax, ay, bx, by, px, py
  );
    logic signed [DW-1:0] adx, ady, bdx, bdy;
    logic signed [PW-1:0] p0, p1;
    adx = $signed({ax[SIGFIG-1], ax}) - $signed({px[SIGFIG-1], px});
    ady = $signed({ay[SIGFIG-1], ay}) - $signed({py[SIGFIG-1], py});
    bdx = $signed({bx[SIGFIG-1], bx}) - $signed({px[SIGFIG-1], px});
    bdy = $signed({by[SIGFIG-1], by}) - $signed({py[SIGFIG-1], py});
    p0 = PW'(adx) * PW'(bdy);
    p1 = PW'(bdx) * PW'(ady);
    return EW'(p0) - EW'(p1);
  endfunction

  logic [MULTI_SAMP-1:0] exp_mask;

  // Top-left style rule: e1 must be strictly negative, e0/e2 may be zero.
  always_comb begin
    logic signed [EW-1:0] e0, e1, e2;
    exp_mask = '0;
    for (int l = 0; l < MULTI_SAMP; l++) begin
      e0 = edge_f(tri_R16S[0][0], tri_R16S[0][1],
                  tri_R16S[1][0], tri_R16S[1][1],
                  sample_R16S[l][0], sample_R16S[l][1]);
      e1 = edge_f(tri_R16S[1][0], tri_R16S[1][1],
                  tri_R16S[2][0], tri_R16S[2][1],
                  sample_R16S[l][0], sample_R16S[l][1]);
      e2 = edge_f(tri_R16S[2][0], tri_R16S[2][1],
                  tri_R16S[0][0], tri_R16S[0][1],
                  sample_R16S[l][0], sample_R16S[l][1]);
      exp_mask[l] = (e0[EW-1] || e0 == '0) && e1[EW-1] &&
                    (e2[EW-1] || e2 == '0);
    end
  end

  logic unused_ok;
  assign unused_ok = ^{tri_R16S[0][2], tri_R16S[1][2],
                       tri_R16S[2][2], RADIX[0]};

  logic [MULTI_SAMP-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [GW-1:0] age, age_inc;
  logic [1:0] state, state_nxt;
  logic active, empty, full, strobe, push_req;
  logic push, pop, unf_ev, ovf_ev, tmo_ev;
  logic [MULTI_SAMP-1:0] diff;
  logic [AW:0] lvl_nxt;

  assign level    = wptr - rptr;
  assign halted   = state == S_HALT;
  assign active   = !halted && !flush;
  assign empty    = level == '0;
  assign full     = level == (AW+1)'(FIFO_DEPTH);
  assign push_req = validSamp_R16H && active;
  assign strobe   = result_valid_R18H && active;
  assign pop      = strobe && !empty;
  assign unf_ev   = strobe && empty;
  assign push     = push_req && (!full || pop);
  assign ovf_ev   = push_req && full && !pop;
  assign age_inc  = age + 1'b1;
  assign tmo_ev   = active && !empty && !pop &&
                    age_inc == GW'(MAX_LAT);
  assign diff     = hit_valid_R18H ^ mem[rptr[AW-1:0]];
  assign lvl_nxt  = level + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      flush:              state_nxt = S_IDLE;
      !flush && halted:   state_nxt = S_HALT;
      ovf_ev || tmo_ev:   state_nxt = S_HALT;
      default:
        state_nxt = (lvl_nxt == '0) ? S_IDLE : S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= exp_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wptr          <= '0;
      rptr          <= '0;
      age           <= '0;
      check_cnt     <= '0;
      err_cnt       <= '0;
      err_lane_mask <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        age  <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        if (pop || (push && empty)) age <= '0;
        else if (active && !empty)  age <= age_inc;
      end
      if (pop) begin
        if (~&check_cnt) check_cnt <= check_cnt + 1'b1;
        if (diff != '0) begin
          if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
          err_lane_mask <= err_lane_mask | diff;
        end
      end
      if (unf_ev) underflow <= 1'b1;
      if (ovf_ev) overflow  <= 1'b1;
      if (tmo_ev) timeout   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smpl_hit_chk.sv
// tb_smpl_hit_chk: directed + random stimulus against a queue-based model.
// Expected masks come from plain 64-bit edge arithmetic on the coordinates.
module tb_smpl_hit_chk;

  localparam int SF = 24;
  localparam int MS = 4;
  localparam int D  = 8;
  localparam int ML = 32;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][2:0][SF-1:0] tri_v;
  logic [MS-1:0][1:0][SF-1:0] smp;
  logic vs = 1'b0, rv = 1'b0, fl = 1'b0;
  logic [MS-1:0] hv = '0;
  logic [31:0] check_cnt, err_cnt;
  logic [MS-1:0] err_lane_mask;
  logic overflow, underflow, timeout, halted;
  logic [3:0] level;

  int tx[3], ty[3], sx[MS], sy[MS];

  always_comb begin
    for (int v = 0; v < 3; v++) begin
      tri_v[v][0] = tx[v][SF-1:0];
      tri_v[v][1] = ty[v][SF-1:0];
      tri_v[v][2] = '0;
    end
    for (int l = 0; l < MS; l++) begin
      smp[l][0] = sx[l][SF-1:0];
      smp[l][1] = sy[l][SF-1:0];
    end
  end

  smpl_hit_chk dut (
    .clk(clk), .rst(rst),
    .tri_R16S(tri_v), .sample_R16S(smp),
    .validSamp_R16H(vs), .result_valid_R18H(rv),
    .hit_valid_R18H(hv), .flush(fl),
    .check_cnt(check_cnt), .err_cnt(err_cnt),
    .err_lane_mask(err_lane_mask),
    .overflow(overflow), .underflow(underflow),
    .timeout(timeout), .halted(halted), .level(level)
  );

  logic [MS-1:0] q[$];
  longint m_chk, m_err;
  logic [MS-1:0] m_mask;
  bit m_ovf, m_unf, m_tmo, m_halt;
  int m_age;
  int total = 0, bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint edg(longint ax, ay, bx, by, px, py);
    return (ax - px) * (by - py) - (bx - px) * (ay - py);
  endfunction

  function automatic logic [MS-1:0] ref_mask();
    logic [MS-1:0] m;
    longint e0, e1, e2;
    m = '0;
    for (int l = 0; l < MS; l++) begin
      e0 = edg(tx[0], ty[0], tx[1], ty[1], sx[l], sy[l]);
      e1 = edg(tx[1], ty[1], tx[2], ty[2], sx[l], sy[l]);
      e2 = edg(tx[2], ty[2], tx[0], ty[0], sx[l], sy[l]);
      m[l] = (e0 <= 0) && (e1 < 0) && (e2 <= 0);
    end
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_chk = 0; m_err = 0; m_mask = '0;
    m_ovf = 0; m_unf = 0; m_tmo = 0; m_halt = 0; m_age = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".level"}, level, q.size());
    chk({tag, ".halted"}, halted, m_halt);
    chk({tag, ".chk"}, check_cnt, m_chk);
    chk({tag, ".err"}, err_cnt, m_err);
    chk({tag, ".mask"}, err_lane_mask, m_mask);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".unf"}, underflow, m_unf);
    chk({tag, ".tmo"}, timeout, m_tmo);
  endtask

  task automatic cyc(bit push, bit strobe, logic [MS-1:0] hit, bit flush);
    logic [MS-1:0] em, head;
    int sz;
    bit popped;
    @(negedge clk);
    vs = push; rv = strobe; hv = hit; fl = flush;
    em = ref_mask();
    @(posedge clk);
    if (flush) begin
      q.delete(); m_age = 0; m_halt = 0;
    end else if (!m_halt) begin
      sz = q.size();
      popped = 0;
      if (strobe) begin
        if (sz == 0) m_unf = 1;
        else begin
          head = q.pop_front();
          popped = 1;
          if (m_chk < MAXC) m_chk++;
          if (head != hit) begin
            if (m_err < MAXC) m_err++;
            m_mask |= head ^ hit;
          end
        end
      end
      if (push) begin
        if (sz == D && !popped) begin m_ovf = 1; m_halt = 1; end
        else q.push_back(em);
      end
      if (popped || (push && sz == 0)) m_age = 0;
      else if (sz > 0) begin
        m_age++;
        if (m_age == ML) begin m_tmo = 1; m_halt = 1; end
      end
    end
    #1;
    check_all("cyc");
  endtask

  function automatic logic [MS-1:0] head_hit();
    if (q.size() > 0) return q[0];
    return '0;
  endfunction

  task automatic spec_tri();
    tx[0] = 0;    ty[0] = 0;
    tx[1] = 0;    ty[1] = 4096;
    tx[2] = 4096; ty[2] = 0;
    sx[0] = 1024; sy[0] = 1024;
    sx[1] = 5120; sy[1] = 5120;
    sx[2] = 2048; sy[2] = 2048;
    sx[3] = 0;    sy[3] = 0;
  endtask

  function automatic int rcoord();
    if ($urandom % 2) return (int'($urandom_range(0, 16)) - 8) <<< 10;
    return int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
  endfunction

  task automatic rand_coords();
    for (int v = 0; v < 3; v++) begin tx[v] = rcoord(); ty[v] = rcoord(); end
    for (int l = 0; l < MS; l++) begin sx[l] = rcoord(); sy[l] = rcoord(); end
  endtask

  longint base;
  logic [MS-1:0] rh;

  initial begin
    spec_tri();
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1'b0;

    cyc(1, 0, '0, 0);
    chk("t1_head", q[0], 4'b1001);
    repeat (2) cyc(0, 0, '0, 0);
    cyc(0, 1, 4'b1001, 0);
    chk("t1_chk", check_cnt, 1);
    chk("t1_err", err_cnt, 0);

    cyc(1, 0, '0, 0);
    repeat (2) cyc(0, 0, '0, 0);
    cyc(0, 1, 4'b1011, 0);
    chk("t2_err", err_cnt, 1);
    chk("t2_mask", err_lane_mask, 4'b0010);

    repeat (8) cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_halt", halted, 1);
    chk("t3_lvl", level, 8);
    cyc(0, 0, '0, 1);
    chk("t3_flvl", level, 0);
    chk("t3_fhalt", halted, 0);
    chk("t3_fovf", overflow, 1);

    cyc(0, 1, 4'b1001, 0);
    chk("t4_unf", underflow, 1);
    chk("t4_chk", check_cnt, 2);
    cyc(1, 0, '0, 0);
    cyc(0, 1, 4'b1001, 0);
    chk("t4_chk2", check_cnt, 3);

    cyc(1, 0, '0, 0);
    repeat (ML - 1) cyc(0, 0, '0, 0);
    chk("t5_tmo0", timeout, 0);
    cyc(0, 0, '0, 0);
    chk("t5_tmo", timeout, 1);
    chk("t5_halt", halted, 1);
    cyc(0, 1, 4'b1001, 0);
    chk("t5_chk", check_cnt, 3);
    chk("t5_lvl", level, 1);
    cyc(0, 0, '0, 1);

    repeat (D) cyc(1, 0, '0, 0);
    base = m_chk;
    for (int i = 0; i < 100; i++) begin
      rand_coords();
      cyc(1, 1, head_hit(), 0);
    end
    chk("t6_lvl", level, 8);
    chk("t6_chk", check_cnt, base + 100);

    @(negedge clk);
    vs = 1'b1; rv = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    chk("rst_lvl", level, 0);
    @(negedge clk);
    rst = 1'b0; vs = 1'b0; rv = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rand_coords();
      rh = ($urandom % 4 != 0) ? head_hit() : 4'($urandom);
      cyc($urandom % 2 == 0, $urandom % 5 < 2, rh, $urandom % 32 == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
